// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier operand sequencer.
//   - seq_state_t : sequencer FSM encoding (IDLE=0, ARM=1, RUN=2, HOLD=3)
//   - W_DEF       : default operand width (product is 2*W)
//   - DEPTH_DEF   : default operand FIFO depth (power of two, >= 2)
//   - TIMEOUT_DEF : default number of RUN cycles allowed before a forced completion
package mult_pkg;

    localparam int W_DEF       = 4;
    localparam int DEPTH_DEF   = 4;
    localparam int TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_HOLD = 2'd3
    } seq_state_t;

endpackage : mult_pkg

// File: rtl/mult_operand_fifo.sv
// Operand-pair FIFO for the multiplier sequencer.
// Registered storage, head of queue visible combinationally on pop_data.
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset; empties the FIFO
//   push       in   write push_data (ignored when full)
//   push_data  in   DW-bit entry
//   pop        in   discard head entry (ignored when empty)
//   pop_data   out  current head entry
//   full       out  occupancy == DEPTH
//   empty      out  occupancy == 0
module mult_operand_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic          full,
    output logic          empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem_reg [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW:0]   count_reg;

    logic do_push;
    logic do_pop;

    assign full     = (count_reg == (PW+1)'(DEPTH));
    assign empty    = (count_reg == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem_reg[rd_ptr_reg];

    // Storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers are PW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (PW+1)'(1);
                2'b01:   count_reg <= count_reg - (PW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule : mult_operand_fifo

// File: rtl/mult_operand_sequencer.sv
// Upstream controller for the serial-parallel multiplier.
// Buffers operand pairs, launches one multiply at a time (clear low while the
// multiplier works), waits for its finish flag or a timeout, and presents the
// product on a valid/ready output.
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   in_valid   in   operand pair offered
//   in_ready   out  FIFO not full
//   in_a/in_b  in   operands (W bits)
//   mul_clr    out  multiplier clear, active-high; high while idle or holding
//   mul_a/b    out  registered operands to the multiplier
//   mul_prod   in   multiplier product (2W bits)
//   mul_finish in   multiplier done flag
//   out_valid  out  result available
//   out_ready  in   consumer accepts result
//   out_prod   out  captured product
//   out_err    out  1 when the result was captured on timeout
//   busy       out  1 whenever the FSM is not IDLE
module mult_operand_sequencer
    import mult_pkg::*;
#(
    parameter int W       = W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_a,
    input  logic [W-1:0]   in_b,
    output logic           mul_clr,
    output logic [W-1:0]   mul_a,
    output logic [W-1:0]   mul_b,
    input  logic [2*W-1:0] mul_prod,
    input  logic           mul_finish,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] out_prod,
    output logic           out_err,
    output logic           busy
);

    localparam int             CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]  TMO_LAST = CW'(TIMEOUT - 1);

    seq_state_t     state_reg,   state_next;
    logic [CW-1:0]  tmo_cnt_reg, tmo_cnt_next;
    logic [W-1:0]   mul_a_reg,   mul_a_next;
    logic [W-1:0]   mul_b_reg,   mul_b_next;
    logic [2*W-1:0] prod_reg,    prod_next;
    logic           err_reg,     err_next;

    logic           fifo_full;
    logic           fifo_empty;
    logic           fifo_pop;
    logic [2*W-1:0] fifo_head;

    mult_operand_fifo #(
        .DW    (2*W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (in_valid && !fifo_full),
        .push_data ({in_a, in_b}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_next   = state_reg;
        tmo_cnt_next = tmo_cnt_reg;
        mul_a_next   = mul_a_reg;
        mul_b_next   = mul_b_reg;
        prod_next    = prod_reg;
        err_next     = err_reg;
        fifo_pop     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    mul_a_next = fifo_head[2*W-1:W];
                    mul_b_next = fifo_head[W-1:0];
                    state_next = ST_ARM;
                end
            end
            ST_ARM: begin
                // mul_finish may still reflect the previous operation here,
                // so it is deliberately not looked at in this state.
                tmo_cnt_next = '0;
                state_next   = ST_RUN;
            end
            ST_RUN: begin
                if (mul_finish) begin
                    prod_next  = mul_prod;
                    err_next   = 1'b0;
                    state_next = ST_HOLD;
                end else if (tmo_cnt_reg == TMO_LAST) begin
                    prod_next  = mul_prod;
                    err_next   = 1'b1;
                    state_next = ST_HOLD;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + CW'(1);
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            tmo_cnt_reg <= '0;
            mul_a_reg   <= '0;
            mul_b_reg   <= '0;
            prod_reg    <= '0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            tmo_cnt_reg <= tmo_cnt_next;
            mul_a_reg   <= mul_a_next;
            mul_b_reg   <= mul_b_next;
            prod_reg    <= prod_next;
            err_reg     <= err_next;
        end
    end

    // Decoded from the state register so that an asynchronous reset forces
    // the multiplier into clear in the same instant.
    assign mul_clr   = (state_reg == ST_IDLE) || (state_reg == ST_HOLD);
    assign out_valid = (state_reg == ST_HOLD);
    assign busy      = (state_reg != ST_IDLE);
    assign in_ready  = !fifo_full;
    assign mul_a     = mul_a_reg;
    assign mul_b     = mul_b_reg;
    assign out_prod  = prod_reg;
    assign out_err   = err_reg;

endmodule : mult_operand_sequencer
